// File: rtl/bin2bcd_scan_if.sv
// Display-feeder bus: value/strobe from the producer, BCD nibble and digit select
// toward the 7-segment decoder, plus the conversion busy flag.
interface bin2bcd_scan_if;
    logic [7:0] din;
    logic       load;
    logic       busy;
    logic [3:0] bcd;
    logic [2:0] dig;

    // load is a one-cycle strobe, sampled only while busy is low; no queuing.
    modport master (
        output din,
        output load,
        input  busy,
        input  bcd,
        input  dig
    );

    modport slave (
        input  din,
        input  load,
        output busy,
        output bcd,
        output dig
    );
endinterface

// File: rtl/bin2bcd_scan.sv
// 8-bit binary to 3-digit BCD converter (sequential double-dabble, one bit per clock)
// feeding a time-multiplexed single-nibble display bus with optional leading-zero blanking.
module bin2bcd_scan #(
    parameter int SCAN_DIV = 16,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    bin2bcd_scan_if.slave  bus,
    output logic           conv_dbg_o
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [19:0]    shift_q, shift_d;
    logic [2:0]     iter_q, iter_d;
    logic [11:0]    disp_q, disp_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [1:0]     scan_q, scan_d;
    logic [3:0]     bcd_q, bcd_d;
    logic [2:0]     dig_q, dig_d;

    // One double-dabble iteration: add-3 on any BCD nibble >= 5, then shift left.
    function automatic logic [19:0] dabble_step(input logic [19:0] v);
        logic [19:0] r;
        r = v;
        for (int k = 0; k < 3; k++) begin
            if (r[8 + 4*k +: 4] >= 4'd5) begin
                r[8 + 4*k +: 4] = r[8 + 4*k +: 4] + 4'd3;
            end
        end
        return {r[18:0], 1'b0};
    endfunction

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        iter_d  = iter_q;
        disp_d  = disp_q;
        case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    shift_d = {12'd0, bus.din};
                    iter_d  = 3'd0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                shift_d = dabble_step(shift_q);
                iter_d  = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    disp_d  = shift_d[19:8];
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        presc_d = presc_q + PW'(1);
        scan_d  = scan_q;
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            scan_d  = (scan_q == 2'd2) ? 2'd0 : scan_q + 2'd1;
        end
    end

    // Outputs are built from the next display/scan values so a finished
    // conversion shows up on the bus one edge after the last iteration.
    always_comb begin
        bcd_d = disp_d[3:0];
        dig_d = 3'b001;
        case (scan_d)
            2'd1: begin
                bcd_d = disp_d[7:4];
                dig_d = 3'b010;
                if (BLANK_LZ && disp_d[11:8] == 4'd0 && disp_d[7:4] == 4'd0) begin
                    dig_d = 3'b000;
                end
            end
            2'd2: begin
                bcd_d = disp_d[11:8];
                dig_d = 3'b100;
                if (BLANK_LZ && disp_d[11:8] == 4'd0) begin
                    dig_d = 3'b000;
                end
            end
            default: begin
                bcd_d = disp_d[3:0];
                dig_d = 3'b001;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            iter_q  <= '0;
            disp_q  <= '0;
            presc_q <= '0;
            scan_q  <= '0;
            bcd_q   <= 4'd0;
            dig_q   <= 3'b001;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            iter_q  <= iter_d;
            disp_q  <= disp_d;
            presc_q <= presc_d;
            scan_q  <= scan_d;
            bcd_q   <= bcd_d;
            dig_q   <= dig_d;
        end
    end

    assign bus.busy   = (state_q == S_CONV);
    assign bus.bcd    = bcd_q;
    assign bus.dig    = dig_q;
    assign conv_dbg_o = (state_q == S_CONV);

endmodule
